// File: rtl/id_redirect.sv
// id_redirect: IF/ID pipeline register with decode-stage branch/jump
// resolution, load-use and branch-operand stalls, and event counters.
module id_redirect #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instr_fetch,
    input  logic [WIDTH-1:0] pc_fetch,
    input  logic [WIDTH-1:0] rd1_decode,
    input  logic [WIDTH-1:0] rd2_decode,
    input  logic [WIDTH-1:0] alu_out_mem,
    input  logic             regwrite_ex,
    input  logic             memtoreg_ex,
    input  logic [4:0]       writereg_ex,
    input  logic             regwrite_mem,
    input  logic             memtoreg_mem,
    input  logic [4:0]       writereg_mem,
    output logic [WIDTH-1:0] instr_decode,
    output logic [WIDTH-1:0] pc_plus4_decode,
    output logic             valid_decode,
    output logic [4:0]       rs_decode,
    output logic [4:0]       rt_decode,
    output logic             pcsrc_decode,
    output logic             jump_decode,
    output logic [WIDTH-1:0] pc_branch,
    output logic [WIDTH-1:0] pc_jump,
    output logic             stall_pc,
    output logic             flush_decode,
    output logic             flush_ex,
    output logic [31:0]      stall_count,
    output logic [31:0]      redirect_count
);

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
        logic             valid;
    } if_id_t;

    if_id_t if_id_q;
    if_id_t if_id_d;

    logic [5:0]       opcode;
    logic [15:0]      imm;
    logic             is_beq;
    logic             is_bne;
    logic             is_jmp;
    logic             is_branch;
    logic             fwd_a;
    logic             fwd_b;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             taken;
    logic             ex_hit;
    logic             mem_hit;
    logic             lwstall;
    logic             brstall;
    logic             stall;

    assign instr_decode    = if_id_q.instr;
    assign pc_plus4_decode = if_id_q.pc;
    assign valid_decode    = if_id_q.valid;
    assign rs_decode       = if_id_q.instr[25:21];
    assign rt_decode       = if_id_q.instr[20:16];
    assign opcode          = if_id_q.instr[31:26];
    assign imm             = if_id_q.instr[15:0];

    always_comb begin
        is_beq = 1'b0;
        is_bne = 1'b0;
        is_jmp = 1'b0;
        if (valid_decode) begin
            unique case (opcode)
                OP_BEQ:       is_beq = 1'b1;
                OP_BNE:       is_bne = 1'b1;
                OP_J, OP_JAL: is_jmp = 1'b1;
                default:      ;
            endcase
        end
    end

    assign is_branch = is_beq | is_bne;

    // Branch operands may come straight from the MEM-stage ALU result
    assign fwd_a = (rs_decode != 5'd0) && (rs_decode == writereg_mem)
                   && regwrite_mem;
    assign fwd_b = (rt_decode != 5'd0) && (rt_decode == writereg_mem)
                   && regwrite_mem;
    assign op_a  = fwd_a ? alu_out_mem : rd1_decode;
    assign op_b  = fwd_b ? alu_out_mem : rd2_decode;

    assign taken = (is_beq & (op_a == op_b)) | (is_bne & (op_a != op_b));

    assign pc_branch = if_id_q.pc
                     + {{(WIDTH-18){imm[15]}}, imm, 2'b00};
    assign pc_jump   = {if_id_q.pc[WIDTH-1:WIDTH-4],
                        if_id_q.instr[25:0], 2'b00};

    assign ex_hit  = (writereg_ex != 5'd0)
                   && ((writereg_ex == rs_decode)
                    || (writereg_ex == rt_decode));
    assign mem_hit = (writereg_mem != 5'd0)
                   && ((writereg_mem == rs_decode)
                    || (writereg_mem == rt_decode));

    assign lwstall = memtoreg_ex & ex_hit;
    assign brstall = is_branch
                   & ((regwrite_ex & ex_hit) | (memtoreg_mem & mem_hit));
    assign stall   = valid_decode & (lwstall | brstall);

    // A stall defers any redirect until the operands are final
    assign stall_pc     = stall;
    assign flush_ex     = stall;
    assign pcsrc_decode = taken & ~stall;
    assign jump_decode  = is_jmp & ~stall;
    assign flush_decode = pcsrc_decode | jump_decode;

    always_comb begin
        if_id_d = if_id_q;
        unique case (1'b1)
            stall:        ;
            flush_decode: if_id_d = '0;
            default: begin
                if_id_d.instr = instr_fetch;
                if_id_d.pc    = pc_fetch;
                if_id_d.valid = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_q        <= '0;
            stall_count    <= 32'd0;
            redirect_count <= 32'd0;
        end else begin
            if_id_q <= if_id_d;
            if (stall && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
            if (flush_decode && (redirect_count != 32'hFFFF_FFFF))
                redirect_count <= redirect_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_redirect.sv
// Self-checking bench for id_redirect: directed scenarios plus a
// randomized run against a behavioural decode/hazard model.
module tb_id_redirect;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_fetch, pc_fetch, rd1_decode, rd2_decode, alu_out_mem;
    logic        regwrite_ex, memtoreg_ex, regwrite_mem, memtoreg_mem;
    logic [4:0]  writereg_ex, writereg_mem;
    logic [31:0] instr_decode, pc_plus4_decode, pc_branch, pc_jump;
    logic        valid_decode, pcsrc_decode, jump_decode;
    logic [4:0]  rs_decode, rt_decode;
    logic        stall_pc, flush_decode, flush_ex;
    logic [31:0] stall_count, redirect_count;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [31:0] m_instr, m_pc;
    logic        m_valid;
    longint      m_stalls, m_redirs;
    logic        e_pcsrc, e_jump, e_flush, e_stall;
    logic [31:0] e_pcb, e_pcj;

    always #5 clk = ~clk;

    id_redirect #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .instr_fetch(instr_fetch), .pc_fetch(pc_fetch),
        .rd1_decode(rd1_decode), .rd2_decode(rd2_decode),
        .alu_out_mem(alu_out_mem),
        .regwrite_ex(regwrite_ex), .memtoreg_ex(memtoreg_ex),
        .writereg_ex(writereg_ex),
        .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem),
        .writereg_mem(writereg_mem),
        .instr_decode(instr_decode), .pc_plus4_decode(pc_plus4_decode),
        .valid_decode(valid_decode),
        .rs_decode(rs_decode), .rt_decode(rt_decode),
        .pcsrc_decode(pcsrc_decode), .jump_decode(jump_decode),
        .pc_branch(pc_branch), .pc_jump(pc_jump),
        .stall_pc(stall_pc), .flush_decode(flush_decode),
        .flush_ex(flush_ex),
        .stall_count(stall_count), .redirect_count(redirect_count)
    );

    function automatic logic [31:0] sat(input longint v);
        return (v > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic model_reset();
        m_instr  = 32'h0;
        m_pc     = 32'h0;
        m_valid  = 1'b0;
        m_stalls = 0;
        m_redirs = 0;
    endtask

    task automatic model_eval();
        int          op, rs, rt, off;
        logic [31:0] a, b;
        bit          br, jmp, lw, bs, tk;
        op  = int'(m_instr[31:26]);
        rs  = int'(m_instr[25:21]);
        rt  = int'(m_instr[20:16]);
        a   = (rs != 0 && rs == int'(writereg_mem) && regwrite_mem)
              ? alu_out_mem : rd1_decode;
        b   = (rt != 0 && rt == int'(writereg_mem) && regwrite_mem)
              ? alu_out_mem : rd2_decode;
        br  = m_valid && (op == 4 || op == 5);
        jmp = m_valid && (op == 2 || op == 3);
        tk  = br && ((op == 4) ? (a == b) : (a != b));
        lw  = memtoreg_ex && writereg_ex != 0
              && (int'(writereg_ex) == rs || int'(writereg_ex) == rt);
        bs  = br && ((regwrite_ex && writereg_ex != 0
                      && (int'(writereg_ex) == rs || int'(writereg_ex) == rt))
                  || (memtoreg_mem && writereg_mem != 0
                      && (int'(writereg_mem) == rs
                       || int'(writereg_mem) == rt)));
        e_stall = m_valid && (lw || bs);
        e_pcsrc = tk && !e_stall;
        e_jump  = jmp && !e_stall;
        e_flush = e_pcsrc || e_jump;
        off     = $signed(m_instr[15:0]);
        e_pcb   = m_pc + 32'(off * 4);
        e_pcj   = {m_pc[31:28], m_instr[25:0], 2'b00};
    endtask

    task automatic model_clock();
        if (e_stall) m_stalls++;
        if (e_flush) m_redirs++;
        if (!e_stall) begin
            m_instr = e_flush ? 32'h0 : instr_fetch;
            m_pc    = e_flush ? 32'h0 : pc_fetch;
            m_valid = !e_flush;
        end
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        if (rst) model_reset();
        else model_clock();
        @(negedge clk);
    endtask

    task automatic clear_hazards();
        rd1_decode   = 32'h0;
        rd2_decode   = 32'h0;
        alu_out_mem  = 32'h0;
        regwrite_ex  = 1'b0;
        memtoreg_ex  = 1'b0;
        writereg_ex  = 5'd0;
        regwrite_mem = 1'b0;
        memtoreg_mem = 1'b0;
        writereg_mem = 5'd0;
    endtask

    task automatic load(input logic [31:0] ins, input logic [31:0] pc);
        clear_hazards();
        model_eval();
        if (e_flush) begin
            instr_fetch = 32'h0;
            pc_fetch    = 32'h0;
            cycle();
        end
        instr_fetch = ins;
        pc_fetch    = pc;
        cycle();
        instr_fetch = 32'h0;
        pc_fetch    = pc + 32'd4;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        instr_fetch  = 32'h1022_0003;
        pc_fetch     = 32'h0000_0100;
        rd1_decode   = 32'h7;
        rd2_decode   = 32'h7;
        alu_out_mem  = 32'h5;
        regwrite_ex  = 1'b1;
        memtoreg_ex  = 1'b1;
        writereg_ex  = 5'd1;
        regwrite_mem = 1'b1;
        memtoreg_mem = 1'b1;
        writereg_mem = 5'd2;
        model_reset();
        #1;
        n_tests++;
        if ({instr_decode, pc_plus4_decode, valid_decode} !== 65'h0) begin
            n_fail++;
            $display("FAIL reset_ifid: got %h/%h/%b want 0", instr_decode,
                     pc_plus4_decode, valid_decode);
        end
        cycle();
        cycle();
        n_tests++;
        if ({pcsrc_decode, jump_decode, stall_pc, flush_decode, flush_ex,
             pc_branch, pc_jump, stall_count, redirect_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ctl %b%b%b%b%b pcb %h pcj %h cnt %h/%h want 0",
                     pcsrc_decode, jump_decode, stall_pc, flush_decode,
                     flush_ex, pc_branch, pc_jump, stall_count, redirect_count);
        end
        rst = 1'b0;
        clear_hazards();
    endtask

    task automatic test_stream();
        instr_fetch = 32'h2008_0005;
        pc_fetch    = 32'h0000_0004;
        cycle();
        n_tests++;
        if (instr_decode !== 32'h2008_0005 || valid_decode !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_load: got %h v%b want 20080005 v1",
                     instr_decode, valid_decode);
        end
        n_tests++;
        if ({stall_pc, flush_decode, flush_ex} !== 3'b000) begin
            n_fail++;
            $display("FAIL stream_ctl: got %b want 000",
                     {stall_pc, flush_decode, flush_ex});
        end
    endtask

    task automatic test_branch();
        load(32'h1022_0003, 32'h0000_0100);
        rd1_decode  = 32'h7;
        rd2_decode  = 32'h7;
        instr_fetch = 32'h2008_0005;
        #1;
        n_tests++;
        if (pcsrc_decode !== 1'b1 || flush_decode !== 1'b1
            || pc_branch !== 32'h0000_010C) begin
            n_fail++;
            $display("FAIL beq_taken: got pcsrc %b flush %b pcb %h want 1 1 0000010c",
                     pcsrc_decode, flush_decode, pc_branch);
        end
        cycle();
        n_tests++;
        if (valid_decode !== 1'b0 || redirect_count !== 32'd1) begin
            n_fail++;
            $display("FAIL beq_squash: got v%b rc %0d want v0 rc 1",
                     valid_decode, redirect_count);
        end
        load(32'h1422_0003, 32'h0000_0100);
        rd1_decode = 32'h7;
        rd2_decode = 32'h7;
        #1;
        n_tests++;
        if (pcsrc_decode !== 1'b0 || flush_decode !== 1'b0) begin
            n_fail++;
            $display("FAIL bne_equal: got pcsrc %b flush %b want 0 0",
                     pcsrc_decode, flush_decode);
        end
        rd2_decode = 32'h9;
        #1;
        n_tests++;
        if (pcsrc_decode !== 1'b1) begin
            n_fail++;
            $display("FAIL bne_differ: got pcsrc %b want 1", pcsrc_decode);
        end
        cycle();
    endtask

    task automatic test_jump();
        load(32'h0800_0040, 32'h1000_0008);
        #1;
        n_tests++;
        if (jump_decode !== 1'b1 || pc_jump !== 32'h1000_0100
            || flush_decode !== 1'b1 || pcsrc_decode !== 1'b0) begin
            n_fail++;
            $display("FAIL j_redirect: got jump %b pcj %h flush %b pcsrc %b want 1 10000100 1 0",
                     jump_decode, pc_jump, flush_decode, pcsrc_decode);
        end
        cycle();
        load(32'h0C00_0040, 32'h2000_0004);
        #1;
        n_tests++;
        if (jump_decode !== 1'b1 || pc_jump !== 32'h2000_0100) begin
            n_fail++;
            $display("FAIL jal_redirect: got jump %b pcj %h want 1 20000100",
                     jump_decode, pc_jump);
        end
        cycle();
    endtask

    task automatic test_load_use();
        load(32'h0100_4820, 32'h0000_0200);
        memtoreg_ex = 1'b1;
        regwrite_ex = 1'b1;
        writereg_ex = 5'd8;
        instr_fetch = 32'h2008_0005;
        #1;
        n_tests++;
        if ({stall_pc, flush_ex, flush_decode} !== 3'b110) begin
            n_fail++;
            $display("FAIL lw_stall: got stall/fex/fdec %b want 110",
                     {stall_pc, flush_ex, flush_decode});
        end
        cycle();
        clear_hazards();
        memtoreg_mem = 1'b1;
        regwrite_mem = 1'b1;
        writereg_mem = 5'd8;
        #1;
        n_tests++;
        if (instr_decode !== 32'h0100_4820 || stall_pc !== 1'b0
            || stall_count !== 32'd1) begin
            n_fail++;
            $display("FAIL lw_hold: got %h stall %b sc %0d want 01004820 0 1",
                     instr_decode, stall_pc, stall_count);
        end
        cycle();
        n_tests++;
        if (instr_decode !== 32'h2008_0005) begin
            n_fail++;
            $display("FAIL lw_resume: got %h want 20080005", instr_decode);
        end
        load(32'h0100_4820, 32'h0000_0300);
        memtoreg_ex = 1'b1;
        writereg_ex = 5'd0;
        #1;
        n_tests++;
        if (stall_pc !== 1'b0 || flush_ex !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_r0: got stall %b fex %b want 0 0",
                     stall_pc, flush_ex);
        end
        cycle();
    endtask

    task automatic test_branch_hazard();
        longint s0;
        load(32'h1064_0001, 32'h0000_0300);
        regwrite_ex = 1'b1;
        writereg_ex = 5'd3;
        rd2_decode  = 32'h55;
        #1;
        n_tests++;
        if (stall_pc !== 1'b1 || pcsrc_decode !== 1'b0) begin
            n_fail++;
            $display("FAIL br_ex_stall: got stall %b pcsrc %b want 1 0",
                     stall_pc, pcsrc_decode);
        end
        cycle();
        regwrite_ex  = 1'b0;
        writereg_ex  = 5'd0;
        regwrite_mem = 1'b1;
        writereg_mem = 5'd3;
        alu_out_mem  = 32'h55;
        #1;
        n_tests++;
        if (stall_pc !== 1'b0 || pcsrc_decode !== 1'b1
            || pc_branch !== 32'h0000_0304) begin
            n_fail++;
            $display("FAIL br_mem_fwd: got stall %b pcsrc %b pcb %h want 0 1 00000304",
                     stall_pc, pcsrc_decode, pc_branch);
        end
        cycle();
        load(32'h1064_0001, 32'h0000_0400);
        s0 = m_stalls;
        regwrite_ex = 1'b1;
        memtoreg_ex = 1'b1;
        writereg_ex = 5'd3;
        rd2_decode  = 32'h55;
        #1;
        n_tests++;
        if (stall_pc !== 1'b1) begin
            n_fail++;
            $display("FAIL br_load_c1: got stall %b want 1", stall_pc);
        end
        cycle();
        regwrite_ex  = 1'b0;
        memtoreg_ex  = 1'b0;
        writereg_ex  = 5'd0;
        regwrite_mem = 1'b1;
        memtoreg_mem = 1'b1;
        writereg_mem = 5'd3;
        #1;
        n_tests++;
        if (stall_pc !== 1'b1 || pcsrc_decode !== 1'b0) begin
            n_fail++;
            $display("FAIL br_load_c2: got stall %b pcsrc %b want 1 0",
                     stall_pc, pcsrc_decode);
        end
        cycle();
        regwrite_mem = 1'b0;
        memtoreg_mem = 1'b0;
        writereg_mem = 5'd0;
        rd1_decode   = 32'h55;
        #1;
        n_tests++;
        if (stall_pc !== 1'b0 || pcsrc_decode !== 1'b1
            || stall_count !== sat(s0 + 2)) begin
            n_fail++;
            $display("FAIL br_load_c3: got stall %b pcsrc %b sc %0d want 0 1 %0d",
                     stall_pc, pcsrc_decode, stall_count, sat(s0 + 2));
        end
        cycle();
    endtask

    task automatic test_reset_mid_stall();
        load(32'h0100_4820, 32'h0000_0500);
        memtoreg_ex = 1'b1;
        writereg_ex = 5'd8;
        #1;
        n_tests++;
        if (stall_pc !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: got stall %b want 1", stall_pc);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({instr_decode, pc_plus4_decode, valid_decode, stall_pc,
             flush_ex, flush_decode, stall_count, redirect_count} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h %h v%b st%b fe%b fd%b %h %h want 0",
                     instr_decode, pc_plus4_decode, valid_decode, stall_pc,
                     flush_ex, flush_decode, stall_count, redirect_count);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_hazards();
    endtask

    task automatic test_saturation();
        load(32'h0100_4820, 32'h0000_0600);
        force dut.stall_count = 32'hFFFF_FFFE;
        #1 release dut.stall_count;
        m_stalls    = 64'hFFFF_FFFE;
        memtoreg_ex = 1'b1;
        writereg_ex = 5'd8;
        cycle();
        #1;
        n_tests++;
        if (stall_count !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_stall_top: got %h want ffffffff", stall_count);
        end
        cycle();
        cycle();
        #1;
        n_tests++;
        if (stall_count !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_stall_hold: got %h want ffffffff", stall_count);
        end
        load(32'h0800_0010, 32'h0000_0700);
        force dut.redirect_count = 32'hFFFF_FFFE;
        #1 release dut.redirect_count;
        m_redirs = 64'hFFFF_FFFE;
        cycle();
        load(32'h0800_0020, 32'h0000_0800);
        #1;
        n_tests++;
        if (redirect_count !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_redir_top: got %h want ffffffff", redirect_count);
        end
        cycle();
        #1;
        n_tests++;
        if (redirect_count !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_redir_hold: got %h want ffffffff", redirect_count);
        end
    endtask

    task automatic test_random();
        logic [5:0] op;
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 6))
                0: op = 6'h00;
                1: op = 6'h04;
                2: op = 6'h05;
                3: op = 6'h02;
                4: op = 6'h03;
                5: op = 6'h23;
                default: op = 6'h04;
            endcase
            instr_fetch  = {op, 5'($urandom_range(0, 3)),
                            5'($urandom_range(0, 3)), 16'($urandom)};
            pc_fetch     = $urandom & 32'hFFFF_FFFC;
            rd1_decode   = 32'($urandom_range(0, 1));
            rd2_decode   = 32'($urandom_range(0, 1));
            alu_out_mem  = 32'($urandom_range(0, 1));
            regwrite_ex  = 1'($urandom_range(0, 1));
            memtoreg_ex  = ($urandom_range(0, 3) == 0);
            writereg_ex  = 5'($urandom_range(0, 3));
            regwrite_mem = 1'($urandom_range(0, 1));
            memtoreg_mem = ($urandom_range(0, 3) == 0);
            writereg_mem = 5'($urandom_range(0, 3));
            #1;
            model_eval();
            n_tests++;
            if ({pcsrc_decode, jump_decode, flush_decode, stall_pc, flush_ex}
                !== {e_pcsrc, e_jump, e_flush, e_stall, e_stall}) begin
                n_fail++;
                $display("FAIL rnd_ctl[%0d]: got %b want %b", i,
                         {pcsrc_decode, jump_decode, flush_decode, stall_pc,
                          flush_ex},
                         {e_pcsrc, e_jump, e_flush, e_stall, e_stall});
            end
            n_tests++;
            if (pc_branch !== e_pcb || pc_jump !== e_pcj) begin
                n_fail++;
                $display("FAIL rnd_target[%0d]: got %h/%h want %h/%h", i,
                         pc_branch, pc_jump, e_pcb, e_pcj);
            end
            n_tests++;
            if ({instr_decode, pc_plus4_decode, valid_decode, rs_decode,
                 rt_decode} !== {m_instr, m_pc, m_valid, m_instr[25:21],
                 m_instr[20:16]}) begin
                n_fail++;
                $display("FAIL rnd_ifid[%0d]: got %h %h v%b want %h %h v%b", i,
                         instr_decode, pc_plus4_decode, valid_decode,
                         m_instr, m_pc, m_valid);
            end
            n_tests++;
            if (stall_count !== sat(m_stalls)
                || redirect_count !== sat(m_redirs)) begin
                n_fail++;
                $display("FAIL rnd_count[%0d]: got %0d/%0d want %0d/%0d", i,
                         stall_count, redirect_count, sat(m_stalls),
                         sat(m_redirs));
            end
            cycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_branch();
        test_jump();
        test_load_use();
        test_branch_hazard();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
